// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - D-stage stall detection and E/M/W forwarding selects from shadow pipeline state
module hazard_tracker (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_TuseRs,
    input  logic [1:0]  D_TuseRt,
    input  logic [4:0]  D_wAddr,
    input  logic        D_regWrite,
    input  logic [1:0]  D_ETnew,
    output logic        stall,
    output logic [1:0]  fwd_D_rs,
    output logic [1:0]  fwd_D_rt,
    output logic [1:0]  fwd_E_rs,
    output logic [1:0]  fwd_E_rt,
    output logic        fwd_M_rt,
    output logic [31:0] stall_count
);

    logic [4:0]  e_rs_q, e_rt_q, e_waddr_q, m_rt_q, m_waddr_q, w_waddr_q;
    logic        e_we_q, m_we_q, w_we_q;
    logic [1:0]  e_tnew_q, m_tnew_q;
    logic [4:0]  e_rs_d, e_rt_d, e_waddr_d;
    logic        e_we_d;
    logic [1:0]  e_tnew_d, m_tnew_d;
    logic [31:0] stall_count_q, stall_count_d;

    // The nearest matching stage decides; an older stage is only consulted when E misses.
    function automatic logic stall_for(input logic [4:0] x, input logic [1:0] tuse);
        logic res;
        res = 1'b0;
        if (tuse != 2'b11 && x != 5'd0) begin
            if (e_we_q && e_waddr_q == x)
                res = (e_tnew_q > tuse);
            else if (m_we_q && m_waddr_q == x)
                res = (m_tnew_q > tuse);
        end
        return res;
    endfunction

    function automatic logic [1:0] fwd_d_for(input logic [4:0] x);
        logic [1:0] sel;
        sel = 2'b00;
        if (e_we_q && e_waddr_q == x)
            sel = (e_tnew_q == 2'd0) ? 2'b01 : 2'b00;
        else if (m_we_q && m_waddr_q == x)
            sel = (m_tnew_q == 2'd0) ? 2'b10 : 2'b00;
        else if (w_we_q && w_waddr_q == x)
            sel = 2'b11;
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e_for(input logic [4:0] x);
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we_q && m_waddr_q == x && m_tnew_q == 2'd0)
            sel = 2'b01;
        else if (w_we_q && w_waddr_q == x)
            sel = 2'b10;
        return sel;
    endfunction

    always_comb begin
        stall    = stall_for(D_rs, D_TuseRs) | stall_for(D_rt, D_TuseRt);
        fwd_D_rs = fwd_d_for(D_rs);
        fwd_D_rt = fwd_d_for(D_rt);
        fwd_E_rs = fwd_e_for(e_rs_q);
        fwd_E_rt = fwd_e_for(e_rt_q);
        fwd_M_rt = w_we_q && (w_waddr_q == m_rt_q);
    end

    always_comb begin
        e_rs_d        = D_rs;
        e_rt_d        = D_rt;
        e_waddr_d     = D_wAddr;
        e_we_d        = D_regWrite && (D_wAddr != 5'd0);
        e_tnew_d      = D_ETnew;
        m_tnew_d      = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        stall_count_d = stall_count_q;
        if (stall) begin
            e_rs_d        = 5'd0;
            e_rt_d        = 5'd0;
            e_waddr_d     = 5'd0;
            e_we_d        = 1'b0;
            e_tnew_d      = 2'd0;
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_rs_q        <= 5'd0;
            e_rt_q        <= 5'd0;
            e_waddr_q     <= 5'd0;
            e_we_q        <= 1'b0;
            e_tnew_q      <= 2'd0;
            m_rt_q        <= 5'd0;
            m_waddr_q     <= 5'd0;
            m_we_q        <= 1'b0;
            m_tnew_q      <= 2'd0;
            w_waddr_q     <= 5'd0;
            w_we_q        <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            e_rs_q        <= e_rs_d;
            e_rt_q        <= e_rt_d;
            e_waddr_q     <= e_waddr_d;
            e_we_q        <= e_we_d;
            e_tnew_q      <= e_tnew_d;
            m_rt_q        <= e_rt_q;
            m_waddr_q     <= e_waddr_q;
            m_we_q        <= e_we_q;
            m_tnew_q      <= m_tnew_d;
            w_waddr_q     <= m_waddr_q;
            w_we_q        <= m_we_q;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - directed scoreboard bench for hazard_tracker
module tb_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, D_wAddr;
    logic [1:0]  D_TuseRs, D_TuseRt, D_ETnew;
    logic        D_regWrite;
    logic        stall, fwd_M_rt;
    logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic [31:0] stall_count;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    localparam int S_STALL = 0, S_FDRS = 1, S_FDRT = 2, S_FERS = 3, S_FERT = 4, S_FMRT = 5, S_CNT = 6;

    hazard_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_TuseRs   (D_TuseRs),
        .D_TuseRt   (D_TuseRt),
        .D_wAddr    (D_wAddr),
        .D_regWrite (D_regWrite),
        .D_ETnew    (D_ETnew),
        .stall      (stall),
        .fwd_D_rs   (fwd_D_rs),
        .fwd_D_rt   (fwd_D_rt),
        .fwd_E_rs   (fwd_E_rs),
        .fwd_E_rt   (fwd_E_rt),
        .fwd_M_rt   (fwd_M_rt),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_STALL: return {31'd0, stall};
            S_FDRS:  return {30'd0, fwd_D_rs};
            S_FDRT:  return {30'd0, fwd_D_rt};
            S_FERS:  return {30'd0, fwd_E_rs};
            S_FERT:  return {30'd0, fwd_E_rt};
            S_FMRT:  return {31'd0, fwd_M_rt};
            default: return stall_count;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            compared++;
            assert (o === e.val) else begin
                mismatched++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tr,
                         input logic [1:0] tt, input logic [4:0] wa, input logic rw,
                         input logic [1:0] et);
        D_rs = rs; D_rt = rt; D_TuseRs = tr; D_TuseRt = tt;
        D_wAddr = wa; D_regWrite = rw; D_ETnew = et;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd0, 1'b0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        nop();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        nop();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // after reset: add $3,$1,$2
        set_d(5'd1, 5'd2, 2'b01, 2'b01, 5'd3, 1'b1, 2'd1);
        #1;
        expect_val("rst_stall", S_STALL, 0);
        expect_val("rst_fdrs", S_FDRS, 0);
        expect_val("rst_fdrt", S_FDRT, 0);
        expect_val("rst_fers", S_FERS, 0);
        expect_val("rst_fert", S_FERT, 0);
        expect_val("rst_fmrt", S_FMRT, 0);
        expect_val("rst_cnt", S_CNT, 0);
        check();

        // lw $1 -> add $3,$1,$2
        do_reset();
        set_d(5'd5, 5'd1, 2'b01, 2'b11, 5'd1, 1'b1, 2'd2);
        #1; expect_val("lwadd_lw_stall", S_STALL, 0); check();
        tick();
        set_d(5'd1, 5'd2, 2'b01, 2'b01, 5'd3, 1'b1, 2'd1);
        #1; expect_val("lwadd_stall1", S_STALL, 1); check();
        tick();
        #1; expect_val("lwadd_release", S_STALL, 0); expect_val("lwadd_cnt_mid", S_CNT, 1); check();
        tick();
        nop();
        #1; expect_val("lwadd_fers", S_FERS, 2'b10); expect_val("lwadd_cnt", S_CNT, 1); check();

        // lw $1 -> beq $1,$2
        do_reset();
        set_d(5'd5, 5'd1, 2'b01, 2'b11, 5'd1, 1'b1, 2'd2);
        tick();
        set_d(5'd1, 5'd2, 2'b00, 2'b00, 5'd0, 1'b0, 2'd0);
        #1; expect_val("lwbeq_stall1", S_STALL, 1); check();
        tick();
        #1; expect_val("lwbeq_stall2", S_STALL, 1); expect_val("lwbeq_cnt1", S_CNT, 1); check();
        tick();
        #1;
        expect_val("lwbeq_release", S_STALL, 0);
        expect_val("lwbeq_fdrs", S_FDRS, 2'b11);
        expect_val("lwbeq_fdrt", S_FDRT, 2'b00);
        expect_val("lwbeq_cnt", S_CNT, 2);
        check();

        // add $4 -> beq $4,$0
        do_reset();
        set_d(5'd1, 5'd2, 2'b01, 2'b01, 5'd4, 1'b1, 2'd1);
        tick();
        set_d(5'd4, 5'd0, 2'b00, 2'b00, 5'd0, 1'b0, 2'd0);
        #1; expect_val("addbeq_stall", S_STALL, 1); check();
        tick();
        #1;
        expect_val("addbeq_release", S_STALL, 0);
        expect_val("addbeq_fdrs", S_FDRS, 2'b10);
        expect_val("addbeq_fdrt", S_FDRT, 2'b00);
        check();

        // jal -> jr $31
        do_reset();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd31, 1'b1, 2'd0);
        tick();
        set_d(5'd31, 5'd0, 2'b00, 2'b11, 5'd0, 1'b0, 2'd0);
        #1; expect_val("jaljr_stall", S_STALL, 0); expect_val("jaljr_fdrs", S_FDRS, 2'b01); check();

        // ori $0 -> sw $0,0($0)
        do_reset();
        set_d(5'd5, 5'd0, 2'b01, 2'b11, 5'd0, 1'b1, 2'd1);
        tick();
        set_d(5'd0, 5'd0, 2'b01, 2'b10, 5'd0, 1'b0, 2'd0);
        #1; expect_val("r0_stall", S_STALL, 0); expect_val("r0_fdrt", S_FDRT, 0); check();
        tick();
        nop();
        #1; expect_val("r0_fert", S_FERT, 0); check();
        tick();
        #1; expect_val("r0_fmrt", S_FMRT, 0); expect_val("r0_cnt", S_CNT, 0); check();

        // lw $1 -> sw $1,0($5): store data forwarded from W in M
        do_reset();
        set_d(5'd5, 5'd1, 2'b01, 2'b11, 5'd1, 1'b1, 2'd2);
        tick();
        set_d(5'd5, 5'd1, 2'b01, 2'b10, 5'd0, 1'b0, 2'd0);
        #1; expect_val("lwsw_stall", S_STALL, 0); check();
        tick();
        nop();
        #1; expect_val("lwsw_fert", S_FERT, 2'b00); check();
        tick();
        #1; expect_val("lwsw_fmrt", S_FMRT, 1); check();

        // add $4 -> add $5,$4,$4: E operands forwarded from M
        do_reset();
        set_d(5'd1, 5'd2, 2'b01, 2'b01, 5'd4, 1'b1, 2'd1);
        tick();
        set_d(5'd4, 5'd4, 2'b01, 2'b01, 5'd5, 1'b1, 2'd1);
        #1; expect_val("addadd_stall", S_STALL, 0); check();
        tick();
        nop();
        #1; expect_val("addadd_fers", S_FERS, 2'b01); expect_val("addadd_fert", S_FERT, 2'b01); check();

        // reset in the middle of a lw -> beq double stall
        do_reset();
        set_d(5'd5, 5'd1, 2'b01, 2'b11, 5'd1, 1'b1, 2'd2);
        tick();
        set_d(5'd1, 5'd2, 2'b00, 2'b00, 5'd0, 1'b0, 2'd0);
        tick();
        #1; expect_val("midrst_pre_stall", S_STALL, 1); expect_val("midrst_pre_cnt", S_CNT, 1); check();
        reset = 1'b1;
        #1;
        expect_val("midrst_stall", S_STALL, 0);
        expect_val("midrst_cnt", S_CNT, 0);
        expect_val("midrst_fdrs", S_FDRS, 0);
        check();
        tick();
        reset = 1'b0;
        #1;
        expect_val("midrst_after_stall", S_STALL, 0);
        expect_val("midrst_after_fdrs", S_FDRS, 0);
        expect_val("midrst_after_cnt", S_CNT, 0);
        check();
        tick();
        #1; expect_val("midrst_after_cnt2", S_CNT, 0); check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
